// File: rtl/mips_fetch_unit.sv
// rtl/mips_fetch_unit.sv - instruction fetch front end: PC, imem request/response, valid/ready delivery
module mips_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fetch_en,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instruction,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [ADDR_W-1:0] inflight_pc, inflight_pc_nxt;
    logic              discard, discard_nxt;
    logic              capture;
    logic [ADDR_W-1:0] redirect_aligned;
    logic [ADDR_W-1:0] pc_plus4;

    assign redirect_aligned = redirect_pc & ~ADDR_W'(3);
    assign pc_plus4         = pc + ADDR_W'(4);

    assign imem_req    = (state == REQ);
    assign instr_valid = (state == HOLD);
    assign imem_addr   = pc;

    // Redirect wins over every other event; a fetch already granted is marked for discard.
    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        inflight_pc_nxt = inflight_pc;
        discard_nxt     = discard;
        capture         = 1'b0;
        if (redirect_valid) begin
            pc_nxt = redirect_aligned;
        end
        case (state)
            IDLE: begin
                if (!redirect_valid && fetch_en) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (imem_gnt) begin
                    state_nxt       = WAIT;
                    inflight_pc_nxt = pc;
                    discard_nxt     = redirect_valid;
                end else if (!redirect_valid && !fetch_en) begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (discard || redirect_valid) begin
                        discard_nxt = 1'b0;
                        state_nxt   = fetch_en ? REQ : IDLE;
                    end else begin
                        capture   = 1'b1;
                        pc_nxt    = pc_plus4;
                        state_nxt = HOLD;
                    end
                end else if (redirect_valid) begin
                    discard_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid || instr_ready) begin
                    state_nxt = fetch_en ? REQ : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            inflight_pc <= '0;
            discard     <= 1'b0;
            instruction <= '0;
            instr_pc    <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            inflight_pc <= inflight_pc_nxt;
            discard     <= discard_nxt;
            if (capture) begin
                instruction <= imem_rdata;
                instr_pc    <= inflight_pc;
            end
        end
    end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb/tb_mips_fetch_unit.sv - directed self-checking bench for mips_fetch_unit
module tb_mips_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_en, imem_req, imem_gnt, imem_rvalid, instr_valid, instr_ready, redirect_valid;
    logic [31:0] imem_addr, imem_rdata, instruction, instr_pc, redirect_pc;

    logic        fetch_en2, imem_req2, imem_gnt2, imem_rvalid2, instr_valid2, instr_ready2;
    logic [31:0] imem_addr2, imem_rdata2, instruction2, instr_pc2;

    logic        gnt_en, hold_resp, pend;
    logic [31:0] pend_addr;

    int checks = 0;
    int errors = 0;
    logic [31:0] req_q[$];
    logic [31:0] ins_q[$];
    logic [31:0] ipc_q[$];

    always #5 clk = ~clk;

    mips_fetch_unit dut (
        .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    mips_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en2),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_gnt(imem_gnt2),
        .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
        .instr_valid(instr_valid2), .instr_ready(instr_ready2),
        .instruction(instruction2), .instr_pc(instr_pc2),
        .redirect_valid(1'b0), .redirect_pc(32'h0)
    );

    // Memory for dut: responds the cycle after grant unless hold_resp stalls it.
    assign imem_gnt    = imem_req & gnt_en;
    assign imem_rvalid = pend & ~hold_resp;
    assign imem_rdata  = pend_addr | 32'hA000_0000;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend      <= 1'b0;
            pend_addr <= 32'h0;
        end else begin
            if (imem_rvalid) pend <= 1'b0;
            if (imem_req && imem_gnt) begin
                pend      <= 1'b1;
                pend_addr <= imem_addr;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (imem_req && imem_gnt) req_q.push_back(imem_addr);
            if (instr_valid && instr_ready && !redirect_valid) begin
                ins_q.push_back(instruction);
                ipc_q.push_back(instr_pc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        req_q.delete();
        ins_q.delete();
        ipc_q.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0; fetch_en = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        gnt_en = 1'b1; hold_resp = 1'b0;
        fetch_en2 = 1'b0; imem_gnt2 = 1'b0; imem_rvalid2 = 1'b0;
        imem_rdata2 = 32'h0; instr_ready2 = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        clear_q();
    endtask

    task automatic wait_deliv(input int n, input string name);
        int c = 0;
        while (ins_q.size() < n && c < 60) begin
            step();
            c++;
        end
        if (ins_q.size() < n) begin
            checks++; errors++;
            $display("FAIL %s timeout: got %0d deliveries, need %0d", name, ins_q.size(), n);
        end
    endtask

    task automatic wait_req_addr(input logic [31:0] a, input string name);
        int c = 0;
        while (!(imem_req && imem_addr == a) && c < 60) begin
            step();
            c++;
        end
        if (!(imem_req && imem_addr == a)) begin
            checks++; errors++;
            $display("FAIL %s timeout waiting for request at %h (addr %h)", name, a, imem_addr);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; fetch_en = 1'b1;
        step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", instr_valid); end
        checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", instruction); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rst_ipc got %h exp 0", instr_pc); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
        checks++; if (imem_addr2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL rst_addr2 got %h exp fffffffc", imem_addr2); end
    endtask

    task automatic test_sequential();
        do_reset();
        fetch_en = 1'b1; instr_ready = 1'b1;
        wait_deliv(3, "seq");
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (req_q[i] !== 32'(4 * i)) begin errors++; $display("FAIL seq_req%0d got %h exp %h", i, req_q[i], 32'(4 * i)); end
            checks++;
            if (ins_q[i] !== (32'hA000_0000 | 32'(4 * i))) begin errors++; $display("FAIL seq_ins%0d got %h exp %h", i, ins_q[i], 32'hA000_0000 | 32'(4 * i)); end
            checks++;
            if (ipc_q[i] !== 32'(4 * i)) begin errors++; $display("FAIL seq_ipc%0d got %h exp %h", i, ipc_q[i], 32'(4 * i)); end
        end
    endtask

    task automatic test_backpressure();
        int c = 0;
        do_reset();
        fetch_en = 1'b1; instr_ready = 1'b0;
        while (!instr_valid && c < 20) begin step(); c++; end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (instr_valid !== 1'b1 || instruction !== 32'hA000_0000 || instr_pc !== 32'h0 || imem_req !== 1'b0)
                begin errors++; $display("FAIL bp_hold%0d valid %b instr %h pc %h req %b exp 1 a0000000 0 0", i, instr_valid, instruction, instr_pc, imem_req); end
            step();
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        checks++; if (ins_q.size() !== 1) begin errors++; $display("FAIL bp_count got %0d exp 1", ins_q.size()); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_after got %b exp 0", instr_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL bp_next_req req %b addr %h exp 1 4", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        fetch_en = 1'b1; instr_ready = 1'b1;
        wait_req_addr(32'h10, "rw");
        hold_resp = 1'b1;
        clear_q();
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h43;
        step();
        redirect_valid = 1'b0; hold_resp = 1'b0;
        wait_deliv(1, "rw");
        checks++; if (req_q[0] !== 32'h10 || req_q[1] !== 32'h40) begin errors++; $display("FAIL rw_reqs got %h %h exp 10 40", req_q[0], req_q[1]); end
        checks++; if (ipc_q[0] !== 32'h40) begin errors++; $display("FAIL rw_ipc got %h exp 40", ipc_q[0]); end
        checks++; if (ins_q[0] !== 32'hA000_0040) begin errors++; $display("FAIL rw_ins got %h exp a0000040", ins_q[0]); end
    endtask

    task automatic test_redirect_hold();
        int c = 0;
        do_reset();
        fetch_en = 1'b1; instr_ready = 1'b1;
        while (!(instr_valid && instr_pc == 32'h8) && c < 40) begin step(); c++; end
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        clear_q();
        step();
        redirect_valid = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rh_valid got %b exp 0", instr_valid); end
        checks++; if (ins_q.size() !== 0) begin errors++; $display("FAIL rh_deliv got %0d exp 0", ins_q.size()); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL rh_req req %b addr %h exp 1 100", imem_req, imem_addr); end
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        step();
        redirect_valid = 1'b0;
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL rg_req req %b addr %h exp 1 200", imem_req, imem_addr); end
        wait_deliv(1, "rg");
        checks++; if (req_q[0] !== 32'h100 || req_q[1] !== 32'h200) begin errors++; $display("FAIL rg_reqs got %h %h exp 100 200", req_q[0], req_q[1]); end
        checks++; if (ipc_q[0] !== 32'h200 || ins_q[0] !== 32'hA000_0200) begin errors++; $display("FAIL rg_deliv pc %h ins %h exp 200 a0000200", ipc_q[0], ins_q[0]); end
    endtask

    task automatic test_wrap_fetch_en();
        do_reset();
        fetch_en2 = 1'b1; instr_ready2 = 1'b1;
        step();
        checks++; if (imem_req2 !== 1'b1 || imem_addr2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_req req %b addr %h exp 1 fffffffc", imem_req2, imem_addr2); end
        imem_gnt2 = 1'b1;
        step();
        imem_gnt2 = 1'b0; fetch_en2 = 1'b0;
        imem_rvalid2 = 1'b1; imem_rdata2 = 32'h1234_5678;
        step();
        imem_rvalid2 = 1'b0;
        checks++; if (instr_valid2 !== 1'b1 || instruction2 !== 32'h1234_5678 || instr_pc2 !== 32'hFFFF_FFFC)
            begin errors++; $display("FAIL wr_hold valid %b ins %h pc %h exp 1 12345678 fffffffc", instr_valid2, instruction2, instr_pc2); end
        checks++; if (imem_addr2 !== 32'h0) begin errors++; $display("FAIL wr_wrap got %h exp 0", imem_addr2); end
        step();
        checks++; if (instr_valid2 !== 1'b0) begin errors++; $display("FAIL fe_valid got %b exp 0", instr_valid2); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem_req2 !== 1'b0) begin errors++; $display("FAIL fe_noreq%0d got %b exp 0", i, imem_req2); end
            step();
        end
        fetch_en2 = 1'b1;
        step();
        checks++; if (imem_req2 !== 1'b1 || imem_addr2 !== 32'h0) begin errors++; $display("FAIL fe_resume req %b addr %h exp 1 0", imem_req2, imem_addr2); end
        fetch_en2 = 1'b0;
        step();
        checks++; if (imem_req2 !== 1'b0) begin errors++; $display("FAIL fe_drop_req got %b exp 0", imem_req2); end
    endtask

    task automatic test_async_reset();
        do_reset();
        fetch_en = 1'b1; instr_ready = 1'b1;
        wait_req_addr(32'h8, "ar");
        hold_resp = 1'b1;
        step();
        checks++; if (instruction !== 32'hA000_0004 || instr_pc !== 32'h4) begin errors++; $display("FAIL ar_pre ins %h pc %h exp a0000004 4", instruction, instr_pc); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (instruction !== 32'h0 || instr_pc !== 32'h0 || imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'h0)
            begin errors++; $display("FAIL ar_clear ins %h pc %h req %b valid %b addr %h exp all 0", instruction, instr_pc, imem_req, instr_valid, imem_addr); end
        step();
        reset_n = 1'b1; hold_resp = 1'b0;
        clear_q();
        wait_deliv(1, "ar");
        checks++; if (req_q[0] !== 32'h0 || ipc_q[0] !== 32'h0) begin errors++; $display("FAIL ar_restart req %h pc %h exp 0 0", req_q[0], ipc_q[0]); end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_hold();
        test_wrap_fetch_en();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_fetch_unit.md
Name: mips_fetch_unit

Overview:
- Instruction fetch front end that supplies the 32-bit `instruction` word consumed by the non-pipelined MIPS core.
- Owns the program counter and issues word reads to instruction memory over a request/grant/response interface.
- Presents each fetched word to the core with a valid/ready handshake.
- Accepts PC redirects from the core for taken branches and JR, and discards any stale in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
ADDR_W, 32, width of the PC and memory address

Ports:
clk  in  1  clock; all state updates on its rising edge
reset_n  in  1  asynchronous, active-low reset
fetch_en  in  1  permits new memory requests to be issued
imem_req  out  1  read request to instruction memory
imem_addr  out  ADDR_W  word-aligned read address
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  32  read data
instr_valid  out  1  instruction output valid
instr_ready  in  1  core accepts instruction
instruction  out  32  fetched instruction word
instr_pc  out  ADDR_W  address of the presented instruction
redirect_valid  in  1  load new PC (branch/JR target)
redirect_pc  in  ADDR_W  redirect target; bits [1:0] ignored, forced to 0

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, pc=RESET_PC, discard=0.
  - imem_req=0, instr_valid=0, instruction=0, instr_pc=0.
  - imem_addr always equals pc.
  - Reset mid-transaction abandons the access; instruction memory is reset by the same reset_n.
- FSM states: IDLE, REQ, WAIT, HOLD. imem_req=1 exactly when state==REQ. instr_valid=1 exactly when state==HOLD.
- IDLE: if fetch_en=1, go to REQ.
- REQ: on imem_gnt=1, latch inflight_pc=pc and go to WAIT. The request is not committed until gnt, so the address may change or the request may drop before gnt.
- WAIT: on imem_rvalid=1:
  - If discard=0: instruction<=imem_rdata, instr_pc<=inflight_pc, pc<=pc+4, go to HOLD.
  - If discard=1: drop the data, clear discard, go to REQ if fetch_en=1, else IDLE.
  - Response arrives at least 1 cycle after gnt; exactly one response per grant.
- HOLD: instruction and instr_pc stay stable until the transfer completes.
  - A transfer is instr_valid & instr_ready & !redirect_valid.
  - On transfer, go to REQ if fetch_en=1, else IDLE.
  - Best-case throughput: 1 instruction per 3 cycles with 1-cycle memory latency.
- fetch_en=0:
  - No new requests are issued from IDLE, HOLD or WAIT.
  - In REQ without gnt, return to IDLE.
  - An outstanding WAIT still completes into HOLD.
- Redirect (redirect_valid=1) has priority over all other events in the same cycle:
  - pc<=redirect_pc & ~3.
  - IDLE: PC update only.
  - REQ without gnt: stay in REQ; the new address is presented next cycle.
  - REQ with gnt the same cycle: go to WAIT with discard=1.
  - WAIT without rvalid: set discard=1 and stay in WAIT.
  - WAIT with rvalid the same cycle: drop the data and go to REQ/IDLE according to fetch_en.
  - HOLD: instr_valid deasserts next cycle; the held instruction is never delivered (even if instr_ready=1); go to REQ/IDLE according to fetch_en.
- Arithmetic: pc+4 is modulo 2^ADDR_W, so 32'hFFFF_FFFC wraps to 0. No misalignment is possible.
- imem_rvalid in IDLE, REQ or HOLD is ignored (protocol error, no state change).
- Outputs are glitch-free registered state decodes. There is no combinational path from instr_ready to imem_req.

Test Plan:
- Reset & sequential fetch: reset_n low then high, fetch_en=1, memory with 1-cycle latency returning mem[a]=a|32'hA000_0000, instr_ready=1 → addresses 0,4,8 requested in order; instructions A000_0000, A000_0004, A000_0008 delivered with instr_pc 0,4,8.
- Backpressure: instr_ready=0 for 5 cycles in HOLD → instruction/instr_pc stable, imem_req=0 throughout; raising ready yields one transfer, then a request for pc+4.
- Redirect during WAIT: grant at addr 0x10, redirect_pc=0x43 asserted before rvalid → response for 0x10 dropped, next request addr 0x40, delivered instr_pc=0x40, no instruction from 0x10 ever valid.
- Redirect vs ready in HOLD: instr_valid=1 at pc 0x8, redirect_valid=1 & instr_ready=1 same cycle with redirect_pc=0x100 → instr_valid low next cycle, next request 0x100; redirect with gnt same cycle in REQ → WAIT with discard set, that response dropped.
- Wrap & fetch_en: RESET_PC=32'hFFFF_FFFC → first instr_pc FFFF_FFFC, next request addr 0; drop fetch_en during WAIT → that word still delivered, no further imem_req until fetch_en=1.
- Async reset mid-WAIT: reset_n low between gnt and rvalid → outputs cleared immediately without a clock edge; after release, fetch restarts at RESET_PC.
